// File: rtl/lea_pkg.sv
// LEA shared definitions: delta constants, round count,
// key-schedule state encoding and a 32-bit rotate helper.
package lea_pkg;

  localparam int LEA128_ROUNDS = 24;

  localparam logic [31:0] LEA_DELTA [0:7] = '{
    32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
    32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ks_state_e;

  typedef struct packed {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] t3;
  } lea_t_t;

  // Rotate left by n (0..31); n=0 returns x since x>>32 is 0.
  function automatic logic [31:0] rol32(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [5:0] w_r;
    w_r = 6'd32 - {1'b0, n};
    return (x << n) | (x >> w_r);
  endfunction

endpackage

// File: rtl/lea_ks_round.sv
// One combinational LEA key-schedule round update.
// Ports: i_t (T0..T3), i_idx (round i) -> o_t (next T0..T3).
module lea_ks_round
  import lea_pkg::*;
(
  input  lea_t_t     i_t,
  input  logic [4:0] i_idx,
  output lea_t_t     o_t
);

  logic [31:0] w_d;
  logic [31:0] w_d0;
  logic [31:0] w_d1;
  logic [31:0] w_d2;
  logic [31:0] w_d3;

  assign w_d  = LEA_DELTA[{1'b0, i_idx[1:0]}];

  // i <= 23, so i+3 <= 26 never wraps a 5-bit amount.
  assign w_d0 = rol32(w_d, i_idx);
  assign w_d1 = rol32(w_d, i_idx + 5'd1);
  assign w_d2 = rol32(w_d, i_idx + 5'd2);
  assign w_d3 = rol32(w_d, i_idx + 5'd3);

  assign o_t.t0 = rol32(i_t.t0 + w_d0, 5'd1);
  assign o_t.t1 = rol32(i_t.t1 + w_d1, 5'd3);
  assign o_t.t2 = rol32(i_t.t2 + w_d2, 5'd6);
  assign o_t.t3 = rol32(i_t.t3 + w_d3, 5'd11);

endmodule

// File: rtl/lea128_key_schedule.sv
// Iterative LEA-128 key schedule, one 192-bit round key per transfer.
// Ports: clk, rst, start, key[127:0] in; busy, rk_valid, rk, rk_idx,
// done out; rk_ready in (valid/ready stream for the round keys).
module lea128_key_schedule
  import lea_pkg::*;
#(
  parameter int ROUNDS = LEA128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [191:0] rk,
  output logic [4:0]   rk_idx,
  output logic         done
);

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  ks_state_e r_state;
  ks_state_e w_state_nxt;

  lea_t_t     r_t;
  logic [4:0] r_idx;
  logic       r_busy;
  logic       r_valid;
  logic       r_done;

  logic       w_busy_nxt;
  logic       w_valid_nxt;
  logic       w_done_nxt;
  logic       w_upd;
  logic       w_load;
  logic       w_xfer;
  logic       w_last;

  lea_t_t     w_rin;
  lea_t_t     w_rout;
  logic [4:0] w_ridx;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_xfer = r_valid && rk_ready;
  assign w_last = (r_idx == LAST_IDX);

  // Round 0 is computed straight from the key so RK0 is
  // already registered one cycle after start.
  assign w_rin.t0 = w_load ? key[31:0]   : r_t.t0;
  assign w_rin.t1 = w_load ? key[63:32]  : r_t.t1;
  assign w_rin.t2 = w_load ? key[95:64]  : r_t.t2;
  assign w_rin.t3 = w_load ? key[127:96] : r_t.t3;
  assign w_ridx   = w_load ? 5'd0 : r_idx + 5'd1;

  lea_ks_round u_round (
    .i_t   (w_rin),
    .i_idx (w_ridx),
    .o_t   (w_rout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_upd       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_upd       = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = ST_FIN;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_upd = 1'b1;
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_upd) begin
        r_t   <= w_rout;
        r_idx <= w_ridx;
      end
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign done     = r_done;
  assign rk_idx   = r_idx;
  assign rk       = {r_t.t0, r_t.t1, r_t.t2, r_t.t1, r_t.t3, r_t.t1};

endmodule

// File: tb/tb_lea128_key_schedule.sv
// Scoreboard bench for lea128_key_schedule.
// Expected round keys come from a plain-arithmetic LEA-128 model.
module tb_lea128_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [191:0] rk;
  logic [4:0]   rk_idx;
  logic         done;

  lea128_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   idx;
    logic [191:0] rk;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [31:0] D[4] = '{
    32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec
  };
  localparam logic [127:0] K1 =
    128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
  localparam logic [127:0] K2 =
    128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [191:0] RK0_K1 =
    192'h003a0fd4_02497010_194f7db1_02497010_090d0883_02497010;

  function automatic logic [31:0] rol(input logic [31:0] x,
                                      input int n);
    logic [63:0] w;
    w = {x, x} << (n % 32);
    return w[63:32];
  endfunction

  task automatic push_keys(input logic [127:0] k);
    logic [31:0] t[4];
    int sh[4] = '{1, 3, 6, 11};
    for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 4; j++)
        t[j] = rol(t[j] + rol(D[i % 4], i + j), sh[j]);
      q.push_back('{5'(i), {t[0], t[1], t[2], t[1], t[3], t[1]}});
    end
  endtask

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timeout, got no event want event", nm);
  endtask

  // Monitor: pops on every transfer, checks holds on stalls.
  logic         armed = 1'b0;
  logic [191:0] prk;
  logic [4:0]   pidx;

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk("stall_rk", rk, prk);
      chk("stall_idx", 192'(rk_idx), 192'(pidx));
    end
    armed = 1'b0;
    if (!rst && rk_valid) begin
      if (rk_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL xfer: got idx %0d want no transfer", rk_idx);
        end else begin
          e = q.pop_front();
          chk("rk_idx", 192'(rk_idx), 192'(e.idx));
          chk("rk", rk, e.rk);
        end
      end else begin
        armed = 1'b1;
        prk   = rk;
        pidx  = rk_idx;
      end
    end
  end

  task automatic issue(input logic [127:0] k, input bit exp_ok);
    start = 1'b1;
    key   = k;
    if (exp_ok) push_keys(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idx(input logic [4:0] tgt);
    for (int k = 0; k < 100; k++) begin
      if (rk_valid && rk_idx == tgt) return;
      @(posedge clk); #1;
    end
    timeout("wait_idx");
  endtask

  task automatic run_until_done(input bit rnd, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
      if (rnd) rk_ready = 1'($urandom_range(0, 1));
    end
    if (cyc == 0) timeout("done");
    rk_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 192'(busy), 192'(0));
    chk("idle_done", 192'(done), 192'(0));
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_valid", 192'(rk_valid), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_rk", rk, 192'(0));
    chk("rst_idx", 192'(rk_idx), 192'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Known answer
    rk_ready = 1'b1;
    issue(K1, 1'b1);
    chk("kat_rk0", rk, RK0_K1);
    chk("kat_valid", 192'(rk_valid), 192'(1));
    chk("kat_busy", 192'(busy), 192'(1));
    run_until_done(1'b0, cyc);
    chk("kat_done_cycle", 192'(cyc), 192'(24));

    // Backpressure
    rk_ready = 1'($urandom_range(0, 1));
    issue(K1, 1'b1);
    run_until_done(1'b1, cyc);

    // Start while busy is ignored
    rk_ready = 1'b1;
    issue(K1, 1'b1);
    wait_idx(5'd5);
    start = 1'b1;
    key = K2;
    @(posedge clk); #1;
    start = 1'b0;
    key = K1;
    run_until_done(1'b0, cyc);
    chk("busy_start_cycles", 192'(cyc), 192'(18));

    // Reset mid-operation
    issue(K1, 1'b1);
    wait_idx(5'd10);
    rk_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 192'(busy), 192'(0));
    chk("mid_rst_valid", 192'(rk_valid), 192'(0));
    chk("mid_rst_done", 192'(done), 192'(0));
    chk("mid_rst_rk", rk, 192'(0));
    chk("mid_rst_idx", 192'(rk_idx), 192'(0));
    q.delete();
    rst = 1'b0;
    rk_ready = 1'b1;
    issue(K1, 1'b1);
    chk("post_rst_rk0", rk, RK0_K1);
    run_until_done(1'b0, cyc);

    // Back-to-back, all-zero key
    issue(128'h0, 1'b1);
    chk("b2b_t0", 192'(rk[191:160]), 192'(32'h87dfd3b7));
    run_until_done(1'b0, cyc);

    // All-ones key with random stalls
    rk_ready = 1'($urandom_range(0, 1));
    issue({128{1'b1}}, 1'b1);
    run_until_done(1'b1, cyc);

    // Random keys
    repeat (3) begin
      rk_ready = 1'($urandom_range(0, 1));
      issue({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      run_until_done(1'b1, cyc);
    end

    chk("q_drained", 192'(q.size()), 192'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lea128_key_schedule.md
# lea128_key_schedule

Iterative LEA-128 key-schedule engine. It expands a 128-bit master key into the 24 round keys of LEA-128, each 192 bits wide, at one round key per accepted transfer. It consumes the LEA delta constants, indices 0–3, and feeds the round-function datapath through a valid/ready stream.

## Interface
Parameters:
- `ROUNDS`, default 24: number of round keys generated. Fixed at 24 for LEA-128.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: one-cycle request to begin expansion. Sampled only in IDLE.
- `key`, in, 128: master key, sampled on the accepted `start`. Word j is `key[32j+31:32j]` and is loaded as T[j].
- `busy`, out, 1: high from the accepted `start` until `done`, inclusive.
- `rk_valid`, out, 1: `rk` holds a valid round key.
- `rk_ready`, in, 1: downstream accepts `rk` in this cycle.
- `rk`, out, 192: round key as {T0,T1,T2,T1,T3,T1}, with T0 in bits [191:160].
- `rk_idx`, out, 5: index i (0–23) of the round key currently on `rk`.
- `done`, out, 1: one-cycle pulse after RK23 is transferred.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: presents round keys.
  - FIN: one cycle, drives `done`.
- IDLE → RUN on `start`.
  - Registers load from the round-0 update computed directly from `key`.
  - `rk` = RK0, `rk_idx` = 0, `rk_valid` = 1.
- RUN, transfer (`rk_valid` & `rk_ready`) with `rk_idx` < 23:
  - Compute round i+1 from the registered T.
  - Update T, `rk`, and `rk_idx`.
  - `rk_valid` stays high.
- RUN, transfer with `rk_idx` = 23: go to FIN and drop `rk_valid`.
- RUN with `rk_ready` = 0: all outputs are held stable. No change to `rk` or `rk_idx` is permitted while valid and not ready.
- FIN → IDLE after one cycle. `done` = 1 in FIN only.
- Round update for round i, with d = delta[i mod 4]:
  - T0 = ROL1(T0 + ROL_i(d))
  - T1 = ROL3(T1 + ROL_(i+1)(d))
  - T2 = ROL6(T2 + ROL_(i+2)(d))
  - T3 = ROL11(T3 + ROL_(i+3)(d))
- Arithmetic rules:
  - Additions are modulo 2^32; carries are discarded.
  - Rotate amounts are taken mod 32. The maximum amount is 26, so no wrap is actually reached.
- `start` in RUN or FIN is ignored. There is no abort input; abort is done with `rst`.
- Reset at any time, including mid-expansion:
  - next cycle: state = IDLE;
  - `busy`, `rk_valid`, `done` = 0;
  - `rk` = 0, `rk_idx` = 0, T registers = 0.

## Timing
- `start` at cycle n gives `rk_valid` = 1 with RK0 at n+1.
- A transfer at cycle m presents the next key at m+1.
- With `rk_ready` held high, the 24 keys appear on 24 consecutive cycles, n+1 … n+24.
- `done` appears at n+25 and `busy` falls at n+26.
- A new `start` is accepted from n+26 onward.
- All outputs are registered. There is no combinational path from `rk_ready` to `rk_valid`.
- `busy` is high from n+1 through n+25.

## Structure
- Shared package `lea_pkg` holds:
  - `LEA_DELTA[0:7]`: 32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec, 32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957;
  - `LEA128_ROUNDS` = 24;
  - the state encoding.
- The delta is selected by `rk_idx[1:0]`. The index is the next round's index, or 0 when loading.
- Sub-module `lea_ks_round`: purely combinational one-round update.
  - Inputs: T0–T3 and i.
  - Outputs: next T0–T3.
  - Reused later by LEA-192 and LEA-256 schedules.

## Test plan
- Known answer:
  - Stimulus: `key` words T0=3c2d1e0f, T1=78695a4b, T2=b4a59687, T3=f0e1d2c3; `start`; `rk_ready` held at 1.
  - RK0 = 003a0fd4_02497010_194f7db1_02497010_090d0883_02497010 at n+1.
  - All 24 keys match the golden model and `done` pulses at n+25.
- Backpressure:
  - Stimulus: same key, with `rk_ready` toggled at random at 50%.
  - Key sequence is identical to the known-answer run.
  - `rk` and `rk_idx` are stable on every stalled cycle.
  - No index is skipped or duplicated.
- Start while busy:
  - Stimulus: pulse `start` with a different key at RK5.
  - It is ignored and the sequence continues unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst` while RK10 is presented.
  - Next cycle, all outputs are 0 and the state is IDLE.
  - A fresh `start` then reproduces RK0 correctly.
- Back-to-back:
  - Stimulus: `start` again in the first IDLE cycle after `done`, with key = all-zero.
  - T0 of RK0 = ROL1(c3efe9db) = 87dfd3b7.
- Carry and wrap check:
  - Stimulus: `key` = all-ones.
  - All modular-add carries are dropped.
  - RK23 matches the golden model.
